// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm controller family.
//   TMR_W          : width of the sequencing timer
//   TMR_ONE        : timer-width constant 1 (decrement / delay-1 loads)
//   alarm_state_t  : FSM state encoding (OFF=00, ARMED=01, TRIGGERED=10, ALARM_ON=11)
//   lowest_zone()  : index of the lowest set bit of a 4-bit trip vector
package alarm_pkg;

    localparam int unsigned TMR_W = 16;
    localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);

    typedef enum logic [1:0] {
        ST_OFF       = 2'b00,
        ST_ARMED     = 2'b01,
        ST_TRIGGERED = 2'b10,
        ST_ALARM_ON  = 2'b11
    } alarm_state_t;

    function automatic logic [1:0] lowest_zone(input logic [3:0] v);
        logic [1:0] idx;
        casez (v)
            4'b???1: idx = 2'd0;
            4'b??10: idx = 2'd1;
            4'b?100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/alarm_zone_debounce.sv
// One-zone debouncer: zone_q rises on the edge where zone_raw has been
// sampled high for DEB_CYC consecutive edges and falls on the first low sample.
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : clock enable, registers hold when low
//   zone_raw   : raw sensor level
//   zone_q     : qualified zone level
module alarm_zone_debounce #(
    parameter logic [3:0] DEB_CYC = 4'd3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic zone_raw,
    output logic zone_q
);

    // Counts high samples already taken; saturates at DEB_CYC-1 once qualified.
    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            zone_q <= 1'b0;
        end else if (ena) begin
            if (!zone_raw) begin
                cnt    <= '0;
                zone_q <= 1'b0;
            end else if (cnt >= DEB_CYC - 4'd1) begin
                zone_q <= 1'b1;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/alarm_seq_ctrl.sv
// Alarm sequencing controller: arm with exit delay, per-zone debounce,
// entry delay for delayed zones, instant zone 0, bounded siren, coded disarm.
//   clk, rst_n              : clock, asynchronous active-low reset
//   ena                     : clock enable; low freezes everything and ignores requests
//   arm_req                 : arm request (OFF only)
//   disarm_req, code_ok     : disarm, qualified only when both high
//   zone_in, zone_mask      : raw zone levels (zone 0 instant), bypass mask
//   state, next_state       : registered state, combinational next state
//   alarm                   : siren, high while ALARM_ON
//   exit_active             : exit delay running
//   zone_id, zone_valid     : latched trip zone and its valid flag
module alarm_seq_ctrl
    import alarm_pkg::*;
#(
    parameter logic [TMR_W-1:0] EXIT_DLY  = 16'd1000,
    parameter logic [TMR_W-1:0] ENTRY_DLY = 16'd500,
    parameter logic [TMR_W-1:0] SIREN_MAX = 16'd4000,
    parameter logic [3:0]       DEB_CYC   = 4'd3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       arm_req,
    input  logic       disarm_req,
    input  logic       code_ok,
    input  logic [3:0] zone_in,
    input  logic [3:0] zone_mask,
    output logic [1:0] state,
    output logic [1:0] next_state,
    output logic       alarm,
    output logic       exit_active,
    output logic [1:0] zone_id,
    output logic       zone_valid
);

    alarm_state_t     state_q, state_d;
    logic [TMR_W-1:0] timer_q;
    logic             alarm_q, exit_q, zone_valid_q;
    logic [1:0]       zone_id_q;
    logic [3:0]       zone_q;
    logic [3:0]       trip;
    logic             disarm_ok;
    logic             timer_zero;

    for (genvar g = 0; g < 4; g++) begin : g_zone
        alarm_zone_debounce #(
            .DEB_CYC (DEB_CYC)
        ) u_deb (
            .clk      (clk),
            .rst_n    (rst_n),
            .ena      (ena),
            .zone_raw (zone_in[g]),
            .zone_q   (zone_q[g])
        );
    end

    assign disarm_ok  = disarm_req & code_ok;
    assign timer_zero = (timer_q == '0);
    // Trips are blind while disarmed and during the exit delay.
    assign trip = (state_q == ST_OFF || exit_q) ? '0 : (zone_q & ~zone_mask);

    always_comb begin
        state_d = state_q;
        if (ena) begin
            case (state_q)
                ST_OFF: begin
                    if (arm_req) state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (disarm_ok)   state_d = ST_OFF;
                    else if (|trip)  state_d = trip[0] ? ST_ALARM_ON : ST_TRIGGERED;
                end
                ST_TRIGGERED: begin
                    if (disarm_ok)                   state_d = ST_OFF;
                    else if (trip[0] || timer_zero)  state_d = ST_ALARM_ON;
                end
                ST_ALARM_ON: begin
                    if (disarm_ok)       state_d = ST_OFF;
                    else if (timer_zero) state_d = ST_ARMED;
                end
                default: state_d = ST_OFF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_OFF;
            timer_q      <= '0;
            alarm_q      <= 1'b0;
            exit_q       <= 1'b0;
            zone_id_q    <= '0;
            zone_valid_q <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            alarm_q <= (state_d == ST_ALARM_ON);
            if (state_q != ST_OFF && disarm_ok) begin
                timer_q      <= '0;
                exit_q       <= 1'b0;
                zone_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_OFF: begin
                        if (arm_req) begin
                            timer_q <= EXIT_DLY - TMR_ONE;
                            exit_q  <= 1'b1;
                        end
                    end
                    ST_ARMED: begin
                        if (exit_q) begin
                            if (timer_zero) exit_q  <= 1'b0;
                            else            timer_q <= timer_q - TMR_ONE;
                        end else if (|trip) begin
                            zone_id_q    <= lowest_zone(trip);
                            zone_valid_q <= 1'b1;
                            timer_q      <= trip[0] ? (SIREN_MAX - TMR_ONE) : (ENTRY_DLY - TMR_ONE);
                        end
                    end
                    ST_TRIGGERED: begin
                        if (trip[0]) begin
                            zone_id_q <= 2'd0;
                            timer_q   <= SIREN_MAX - TMR_ONE;
                        end else if (timer_zero) begin
                            timer_q <= SIREN_MAX - TMR_ONE;
                        end else begin
                            timer_q <= timer_q - TMR_ONE;
                        end
                    end
                    ST_ALARM_ON: begin
                        // Timer rests at zero on the return to ARMED.
                        if (!timer_zero) timer_q <= timer_q - TMR_ONE;
                    end
                    default: timer_q <= '0;
                endcase
            end
        end
    end

    assign state       = state_q;
    assign next_state  = state_d;
    assign alarm       = alarm_q;
    assign exit_active = exit_q;
    assign zone_id     = zone_id_q;
    assign zone_valid  = zone_valid_q;

endmodule

// File: tb/tb_alarm_seq_ctrl.sv
module tb_alarm_seq_ctrl;

    localparam int unsigned EXIT_N  = 8;
    localparam int unsigned ENTRY_N = 4;
    localparam int unsigned SIREN_N = 16;
    localparam int unsigned DEB_N   = 2;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       arm_req;
    logic       disarm_req;
    logic       code_ok;
    logic [3:0] zone_in;
    logic [3:0] zone_mask;
    logic [1:0] state;
    logic [1:0] next_state;
    logic       alarm;
    logic       exit_active;
    logic [1:0] zone_id;
    logic       zone_valid;

    int checks   = 0;
    int failures = 0;

    alarm_seq_ctrl #(
        .EXIT_DLY  (16'd8),
        .ENTRY_DLY (16'd4),
        .SIREN_MAX (16'd16),
        .DEB_CYC   (4'd2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .arm_req     (arm_req),
        .disarm_req  (disarm_req),
        .code_ok     (code_ok),
        .zone_in     (zone_in),
        .zone_mask   (zone_mask),
        .state       (state),
        .next_state  (next_state),
        .alarm       (alarm),
        .exit_active (exit_active),
        .zone_id     (zone_id),
        .zone_valid  (zone_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: mode 0..3, remaining cycles in the current delay,
    // and per-zone run lengths of consecutive high samples.
    typedef struct packed {
        logic [1:0]      mode;
        logic [7:0]      left;
        logic            ex;
        logic [1:0]      zid;
        logic            zv;
        logic [3:0][7:0] run;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t mstep(input mdl_t c, input logic en, input logic arm,
                                   input logic dis, input logic ok,
                                   input logic [3:0] zin, input logic [3:0] zmask);
        mdl_t n = c;
        logic [3:0] trip;
        int first;
        if (!en) return c;
        trip  = '0;
        first = -1;
        for (int i = 0; i < 4; i++) begin
            trip[i] = (c.run[i] >= 8'(DEB_N)) && !zmask[i] && (c.mode != 2'd0) && !c.ex;
            if (trip[i] && first < 0) first = i;
        end
        if (c.mode != 2'd0 && dis && ok) begin
            n.mode = 2'd0; n.left = '0; n.ex = 1'b0; n.zv = 1'b0;
        end else begin
            case (c.mode)
                2'd0: if (arm) begin
                    n.mode = 2'd1; n.left = 8'(EXIT_N); n.ex = 1'b1;
                end
                2'd1: if (c.ex) begin
                    n.left = c.left - 8'd1;
                    n.ex   = (n.left != 8'd0);
                end else if (first >= 0) begin
                    n.zid = 2'(first);
                    n.zv  = 1'b1;
                    if (first == 0) begin n.mode = 2'd3; n.left = 8'(SIREN_N); end
                    else            begin n.mode = 2'd2; n.left = 8'(ENTRY_N); end
                end
                2'd2: if (trip[0]) begin
                    n.mode = 2'd3; n.zid = 2'd0; n.left = 8'(SIREN_N);
                end else begin
                    n.left = c.left - 8'd1;
                    if (n.left == 8'd0) begin n.mode = 2'd3; n.left = 8'(SIREN_N); end
                end
                default: begin
                    n.left = c.left - 8'd1;
                    if (n.left == 8'd0) n.mode = 2'd1;
                end
            endcase
        end
        for (int i = 0; i < 4; i++)
            n.run[i] = zin[i] ? ((c.run[i] < 8'd200) ? c.run[i] + 8'd1 : c.run[i]) : 8'd0;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m = '0;
        else        m = mstep(m, ena, arm_req, disarm_req, code_ok, zone_in, zone_mask);
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic [1:0] st, input logic al,
                           input logic ex, input logic [1:0] zid, input logic zv);
        chk({tag, ".state"},       8'(state),       8'(st));
        chk({tag, ".alarm"},       8'(alarm),       8'(al));
        chk({tag, ".exit_active"}, 8'(exit_active), 8'(ex));
        chk({tag, ".zone_id"},     8'(zone_id),     8'(zid));
        chk({tag, ".zone_valid"},  8'(zone_valid),  8'(zv));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ena = 1'b1; arm_req = 1'b0; disarm_req = 1'b0; code_ok = 1'b0;
        zone_in = '0; zone_mask = '0;
    endtask

    typedef struct {
        logic       en, arm, dis, ok;
        logic [3:0] zin, zmask;
        logic [1:0] st;
        logic       al, ex;
        logic [1:0] zid;
        logic       zv;
    } vec_t;

    vec_t vecs [32];

    function automatic vec_t mk(input logic arm, input logic [3:0] zin, input logic [1:0] st,
                                input logic al, input logic ex, input logic [1:0] zid,
                                input logic zv);
        vec_t v;
        v.en = 1'b1; v.arm = arm; v.dis = 1'b0; v.ok = 1'b0;
        v.zin = zin; v.zmask = 4'b0000;
        v.st = st; v.al = al; v.ex = ex; v.zid = zid; v.zv = zv;
        return v;
    endfunction

    initial begin
        // Arm, exit delay with a zone held (ignored), delayed-zone trip, entry, siren, re-arm.
        vecs[0] = mk(1'b1, 4'b0000, 2'b01, 1'b0, 1'b1, 2'd0, 1'b0);
        for (int unsigned i = 1; i <= 7; i++)
            vecs[i] = mk(1'b0, 4'b0010, 2'b01, 1'b0, 1'b1, 2'd0, 1'b0);
        vecs[8]  = mk(1'b0, 4'b0000, 2'b01, 1'b0, 1'b0, 2'd0, 1'b0);
        vecs[9]  = mk(1'b0, 4'b0110, 2'b01, 1'b0, 1'b0, 2'd0, 1'b0);
        vecs[10] = mk(1'b0, 4'b0110, 2'b01, 1'b0, 1'b0, 2'd0, 1'b0);
        for (int unsigned i = 11; i <= 14; i++)
            vecs[i] = mk(1'b0, 4'b0000, 2'b10, 1'b0, 1'b0, 2'd1, 1'b1);
        for (int unsigned i = 15; i <= 30; i++)
            vecs[i] = mk(1'b0, 4'b0000, 2'b11, 1'b1, 1'b0, 2'd1, 1'b1);
        vecs[31] = mk(1'b0, 4'b0000, 2'b01, 1'b0, 1'b0, 2'd1, 1'b1);

        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 2'b00, 1'b0, 1'b0, 2'd0, 1'b0);
        chk("reset.next_state", 8'(next_state), 8'h00);
        rst_n = 1'b1;

        for (int unsigned i = 0; i < 32; i++) begin
            ena = vecs[i].en; arm_req = vecs[i].arm; disarm_req = vecs[i].dis;
            code_ok = vecs[i].ok; zone_in = vecs[i].zin; zone_mask = vecs[i].zmask;
            #1;
            chk($sformatf("vec%0d.next_state", i), 8'(next_state), 8'(vecs[i].st));
            tick();
            chk_out($sformatf("vec%0d", i), vecs[i].st, vecs[i].al, vecs[i].ex,
                    vecs[i].zid, vecs[i].zv);
        end

        // Instant zone straight to ALARM_ON; then masked instant zone is ignored.
        idle_inputs();
        zone_in = 4'b0001;
        tick();
        tick();
        chk("inst.pre_state", 8'(state), 8'h01);
        tick();
        chk_out("inst", 2'b11, 1'b1, 1'b0, 2'd0, 1'b1);
        idle_inputs();
        disarm_req = 1'b1; code_ok = 1'b1;
        tick();
        chk_out("disarm1", 2'b00, 1'b0, 1'b0, 2'd0, 1'b0);
        idle_inputs();
        arm_req = 1'b1;
        tick();
        arm_req = 1'b0;
        repeat (EXIT_N) tick();
        chk_out("rearm1", 2'b01, 1'b0, 1'b0, 2'd0, 1'b0);
        zone_mask = 4'b0001; zone_in = 4'b0001;
        repeat (6) tick();
        chk_out("masked", 2'b01, 1'b0, 1'b0, 2'd0, 1'b0);
        zone_in = 4'b0000;
        tick();
        zone_mask = 4'b0000;

        // TRIGGERED: unqualified disarm ignored; qualified disarm beats entry timeout.
        zone_in = 4'b0100;
        tick();
        tick();
        zone_in = 4'b0000;
        tick();
        chk_out("trig2", 2'b10, 1'b0, 1'b0, 2'd2, 1'b1);
        disarm_req = 1'b1; code_ok = 1'b0;
        tick();
        chk("nocode.state", 8'(state), 8'h02);
        disarm_req = 1'b0;
        tick();
        tick();
        disarm_req = 1'b1; code_ok = 1'b0;
        #1;
        chk("timeout.next_state", 8'(next_state), 8'h03);
        code_ok = 1'b1;
        #1;
        chk("disarm_prio.next_state", 8'(next_state), 8'h00);
        tick();
        chk_out("disarm_prio", 2'b00, 1'b0, 1'b0, 2'd2, 1'b0);

        // Glitch rejected; ena low freezes TRIGGERED, then it resumes.
        idle_inputs();
        arm_req = 1'b1;
        tick();
        arm_req = 1'b0;
        repeat (EXIT_N) tick();
        zone_in = 4'b0010;
        tick();
        zone_in = 4'b0000;
        repeat (3) tick();
        chk_out("glitch", 2'b01, 1'b0, 1'b0, 2'd2, 1'b0);
        zone_in = 4'b1000;
        tick();
        tick();
        zone_in = 4'b0000;
        tick();
        chk_out("trig3", 2'b10, 1'b0, 1'b0, 2'd3, 1'b1);
        ena = 1'b0; disarm_req = 1'b1; code_ok = 1'b1; arm_req = 1'b1; zone_in = 4'b0001;
        for (int unsigned k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("frozen%0d.next_state", k), 8'(next_state), 8'h02);
            tick();
            chk($sformatf("frozen%0d.state", k), 8'(state), 8'h02);
        end
        idle_inputs();
        for (int unsigned k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("resume%0d.state", k), 8'(state), 8'h02);
        end
        tick();
        chk_out("resume_alarm", 2'b11, 1'b1, 1'b0, 2'd3, 1'b1);

        // Asynchronous reset mid-cycle in ALARM_ON.
        tick();
        tick();
        chk("pre_reset.alarm", 8'(alarm), 8'h01);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_reset", 2'b00, 1'b0, 1'b0, 2'd0, 1'b0);
        chk("async_reset.next_state", 8'(next_state), 8'h00);
        tick();
        rst_n = 1'b1;
        chk("post_reset.state", 8'(state), 8'h00);

        // Randomized traffic against the reference model.
        for (int unsigned n = 0; n < 4000; n++) begin
            ena        = ($urandom_range(0, 7) != 0);
            arm_req    = ($urandom_range(0, 5) == 0);
            disarm_req = ($urandom_range(0, 11) == 0);
            code_ok    = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) zone_in = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) zone_mask = 4'($urandom_range(0, 15));
            #1;
            chk("rand.next_state", 8'(next_state),
                8'(mstep(m, ena, arm_req, disarm_req, code_ok, zone_in, zone_mask).mode));
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
            end
            tick();
            chk_out("rand", m.mode, (m.mode == 2'd3), m.ex, m.zid, m.zv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
